// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared mode constants and select-width helper for mux_rr_n_a_1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODO_FIJO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    // Never return a zero width, even for degenerate channel counts.
    function automatic int sel_w(input int canales);
        return (canales <= 2) ? 1 : $clog2(canales);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr.sv
// ============================================================================
// Module   : arbitro_rr
// Brief    : Combinational rotating-priority encoder; search starts at ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr #(
    parameter int CANALES = 4,
    parameter int SEL_W   = 2
) (
    input  logic [CANALES-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_hay_ganador,
    output logic [SEL_W-1:0]   o_ganador
);

    logic [SEL_W-1:0] w_idx;

    // Walk the channels once, wrapping at CANALES-1, and keep the first hit.
    always_comb begin
        o_hay_ganador = 1'b0;
        o_ganador     = '0;
        w_idx         = (i_ptr == SEL_W'(CANALES - 1)) ? '0 : i_ptr + 1'b1;
        for (int i = 0; i < CANALES; i++) begin
            if (!o_hay_ganador && i_req[w_idx]) begin
                o_hay_ganador = 1'b1;
                o_ganador     = w_idx;
            end
            w_idx = (w_idx == SEL_W'(CANALES - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_n_a_1.sv
// ============================================================================
// Module   : mux_rr_n_a_1
// Brief    : N-channel registered mux with valid/ready, fixed or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_n_a_1
    import mux_pkg::*;
#(
    parameter int n       = 4,
    parameter int CANALES = 4,
    parameter int SEL_W   = sel_w(CANALES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CANALES*n-1:0] i_datos,
    input  logic [CANALES-1:0]   i_valido,
    output logic [CANALES-1:0]   o_listo,
    input  logic                 i_modo,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [n-1:0]         o_datos,
    output logic [SEL_W-1:0]     o_canal,
    output logic                 o_valido,
    input  logic                 i_listo
);

    logic [n-1:0]     r_datos;
    logic [SEL_W-1:0] r_canal;
    logic             r_valido;
    logic [SEL_W-1:0] r_ptr;

    logic             w_carga;
    logic             w_rr_hay;
    logic [SEL_W-1:0] w_rr_gan;
    logic             w_fijo_hay;
    logic             w_hay;
    logic [SEL_W-1:0] w_gan;
    logic [n-1:0]     w_dato_sel;

    arbitro_rr #(
        .CANALES (CANALES),
        .SEL_W   (SEL_W)
    ) u_arbitro (
        .i_req         (i_valido),
        .i_ptr         (r_ptr),
        .o_hay_ganador (w_rr_hay),
        .o_ganador     (w_rr_gan)
    );

    assign w_carga    = !r_valido || i_listo;
    // Out-of-range selects must never grant, even if the indexed bit aliases.
    assign w_fijo_hay = (int'(i_sel) < CANALES) && i_valido[i_sel];
    assign w_hay      = (i_modo == MODO_RR) ? w_rr_hay : w_fijo_hay;
    assign w_gan      = (i_modo == MODO_RR) ? w_rr_gan : i_sel;
    assign w_dato_sel = i_datos[int'(w_gan)*n +: n];

    always_comb begin
        o_listo = '0;
        if (!i_rst && w_carga && w_hay) begin
            o_listo[w_gan] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_datos  <= '0;
            r_canal  <= '0;
            r_valido <= 1'b0;
            r_ptr    <= SEL_W'(CANALES - 1);
        end else if (w_carga) begin
            if (w_hay) begin
                r_datos  <= w_dato_sel;
                r_canal  <= w_gan;
                r_valido <= 1'b1;
                r_ptr    <= w_gan;
            end else begin
                r_valido <= 1'b0;
            end
        end
    end

    assign o_datos  = r_datos;
    assign o_canal  = r_canal;
    assign o_valido = r_valido;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_n_a_1.sv
// ============================================================================
// Module   : tb_mux_rr_n_a_1
// Brief    : Table-driven self-checking bench with output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_n_a_1;

    localparam int N_BITS = 4;
    localparam int CAN    = 4;
    localparam int SW     = 2;

    logic                  clk;
    logic                  rst;
    logic [CAN*N_BITS-1:0] datos;
    logic [CAN-1:0]        valido;
    logic [CAN-1:0]        listo_o;
    logic                  modo;
    logic [SW-1:0]         sel;
    logic [N_BITS-1:0]     datos_o;
    logic [SW-1:0]         canal_o;
    logic                  valido_o;
    logic                  listo_i;

    mux_rr_n_a_1 #(
        .n       (N_BITS),
        .CANALES (CAN),
        .SEL_W   (SW)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_datos  (datos),
        .i_valido (valido),
        .o_listo  (listo_o),
        .i_modo   (modo),
        .i_sel    (sel),
        .o_datos  (datos_o),
        .o_canal  (canal_o),
        .o_valido (valido_o),
        .i_listo  (listo_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        modo;
        logic [1:0]  sel;
        logic [3:0]  val;
        logic [15:0] dat;
        logic        listo;
        logic [3:0]  e_listo;
        logic        e_ov;
        logic [1:0]  e_oc;
        logic [3:0]  e_od;
    } vec_t;

    typedef struct {
        logic       ov;
        logic [1:0] oc;
        logic [3:0] od;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[20];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic [15:0] d, input logic l,
                                input logic [3:0] el, input logic eov,
                                input logic [1:0] eoc, input logic [3:0] eod);
        vec_t x;
        x.rst = r; x.modo = m; x.sel = s; x.val = v; x.dat = d; x.listo = l;
        x.e_listo = el; x.e_ov = eov; x.e_oc = eoc; x.e_od = eod;
        return x;
    endfunction

    // Drive at negedge, check the combinational ready, queue the registered result.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = v.rst; modo = v.modo; sel = v.sel; valido = v.val;
        datos = v.dat; listo_i = v.listo;
        #1;
        checks++;
        if (listo_o === v.e_listo) passed++;
        else $display("FAIL %s o_listo: got %b expected %b", name, listo_o, v.e_listo);
        e.ov = v.e_ov; e.oc = v.e_oc; e.od = v.e_od;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            if (valido_o === got.ov && canal_o === got.oc && datos_o === got.od) passed++;
            else $display("FAIL %s out: got v=%b c=%0d d=%h expected v=%b c=%0d d=%h",
                          name, valido_o, canal_o, datos_o, got.ov, got.oc, got.od);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; modo = 1'b0; sel = '0; valido = '0; datos = '0; listo_i = 1'b1;

        // Reset: ready must stay low even with a valid selected channel.
        apply(mk(1, 0, 2'd0, 4'b0001, 16'h4321, 1, 4'b0000, 0, 2'd0, 4'h0), "reset0");
        apply(mk(1, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0000, 0, 2'd0, 4'h0), "reset1");

        // Round-robin from reset: 0,1,2,3,0
        tbl[0]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 2'd0, 4'h1);
        tbl[1]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'h2);
        tbl[2]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 2'd2, 4'h3);
        tbl[3]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 2'd3, 4'h4);
        tbl[4]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 2'd0, 4'h1);
        // Backpressure for 3 cycles, then resume on channel 1
        tbl[5]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 2'd0, 4'h1);
        tbl[6]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 2'd0, 4'h1);
        tbl[7]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 2'd0, 4'h1);
        tbl[8]  = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'h2);
        // Only channels 1 and 3 valid
        tbl[9]  = mk(0, 1, 2'd0, 4'b1010, 16'h4321, 1, 4'b1000, 1, 2'd3, 4'h4);
        tbl[10] = mk(0, 1, 2'd0, 4'b1010, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'h2);
        tbl[11] = mk(0, 1, 2'd0, 4'b1010, 16'h4321, 1, 4'b1000, 1, 2'd3, 4'h4);
        tbl[12] = mk(0, 1, 2'd0, 4'b1010, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'h2);
        // Fixed mode, sel=2, channel 2 carries A
        tbl[13] = mk(0, 0, 2'd2, 4'b0100, 16'h0A00, 1, 4'b0100, 1, 2'd2, 4'hA);
        // Fixed sel=1 with only channel 0 valid: hold, then drain to empty
        tbl[14] = mk(0, 0, 2'd1, 4'b0001, 16'h4321, 0, 4'b0000, 1, 2'd2, 4'hA);
        tbl[15] = mk(0, 0, 2'd1, 4'b0001, 16'h4321, 1, 4'b0000, 0, 2'd2, 4'hA);
        tbl[16] = mk(0, 0, 2'd1, 4'b0001, 16'h4321, 1, 4'b0000, 0, 2'd2, 4'hA);
        // ptr kept at 2 from the fixed grant, so round-robin resumes at 3
        tbl[17] = mk(0, 1, 2'd0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 2'd3, 4'h4);
        // Mode change while stalled must not disturb the held word
        tbl[18] = mk(0, 0, 2'd0, 4'b0001, 16'h4321, 0, 4'b0000, 1, 2'd3, 4'h4);
        tbl[19] = mk(0, 0, 2'd0, 4'b0001, 16'h4321, 1, 4'b0001, 1, 2'd0, 4'h1);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while a word is held: discarded, no ready in the reset cycle.
        apply(mk(0, 1, 2'd0, 4'b1111, 16'h8765, 1, 4'b0010, 1, 2'd1, 4'h6), "pre_rst");
        apply(mk(1, 1, 2'd0, 4'b1111, 16'h8765, 1, 4'b0000, 0, 2'd0, 4'h0), "rst_mid");
        apply(mk(0, 1, 2'd0, 4'b1111, 16'h8765, 1, 4'b0001, 1, 2'd0, 4'h5), "post_rst0");
        apply(mk(0, 1, 2'd0, 4'b1111, 16'h8765, 1, 4'b0010, 1, 2'd1, 4'h6), "post_rst1");
        // Empty register loads even with downstream stalled
        apply(mk(0, 1, 2'd0, 4'b0000, 16'h8765, 1, 4'b0000, 0, 2'd1, 4'h6), "drain");
        apply(mk(0, 1, 2'd0, 4'b0001, 16'h8765, 0, 4'b0001, 1, 2'd0, 4'h5), "load_stall");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
